jesd204b_dl_lmfc_ctrl: RTL and testbench

Parametrised successor to the fixed-period JESD204B data-link LMFC logic. It generates the LMFC strobe and its early-warning strobes from runtime F/K configuration, and aligns LMFC phase to SYSREF in one-shot or continuous mode. It also runs the link state machine (CGS → ILAS → DATA) from per-lane sync requests, with transitions on multiframe boundaries. It sits beside the per-lane `jesd204b_dl_tx`/`jesd204b_dl_rx` instances and drives their LMFC, framemark and link-state inputs.

---
 rtl/jesd204b_dl_lmfc_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_jesd204b_dl_lmfc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_dl_lmfc_ctrl.sv
// ---------------------------------------------------------------------------
// jesd204b_dl_lmfc_ctrl
//
// Purpose:
//   Shared JESD204B data-link timing block. Derives the LMFC period
//   P = F*K/OCTET_PER_SENT from runtime configuration and generates the LMFC
//   strobe plus two early-warning strobes. It aligns the LMFC phase to SYSREF
//   (one-shot or continuous) and runs the link state machine
//   CGS -> ILAS -> DATA from the per-lane sync requests.
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   cfg_octets_per_fr   : F (1..255)
//   cfg_frames_per_mf   : K (1..32)
//   cfg_load            : one-cycle pulse, re-latch config and soft reset
//   sysref_mode         : 0 ignore, 1 one-shot, 2 continuous, 3 as 0
//   sysref              : SYSREF, already synchronous to clk
//   lane_enable         : per-lane enable mask
//   sync_request        : per-lane active-high resync request
//   lmfc                : one-cycle strobe at multiframe start
//   lmfc_tx_early       : strobe TX_LEAD cycles before lmfc
//   lmfc_fm_early       : strobe FM_LEAD cycles before lmfc
//   link_state          : 0 CGS, 1 ILAS, 2 DATA, 3 HALT
//   ilas_mf             : current ILAS multiframe index, 0 outside ILAS
//   cfg_error           : latched configuration is invalid
//   sysref_aligned      : a SYSREF alignment happened since config latch
//   sysref_misalign     : pulse when a used SYSREF edge was off-phase
//   resync_count        : saturating count of ILAS/DATA -> CGS drops
// ---------------------------------------------------------------------------
module jesd204b_dl_lmfc_ctrl #(
    parameter int LANES          = 4,
    parameter int OCTET_PER_SENT = 4,
    parameter int CNT_W          = 10,
    parameter int TX_LEAD        = 2,
    parameter int FM_LEAD        = 3,
    parameter int ILAS_MF        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       cfg_octets_per_fr,
    input  logic [5:0]       cfg_frames_per_mf,
    input  logic             cfg_load,
    input  logic [1:0]       sysref_mode,
    input  logic             sysref,
    input  logic [LANES-1:0] lane_enable,
    input  logic [LANES-1:0] sync_request,
    output logic             lmfc,
    output logic             lmfc_tx_early,
    output logic             lmfc_fm_early,
    output logic [1:0]       link_state,
    output logic [3:0]       ilas_mf,
    output logic             cfg_error,
    output logic             sysref_aligned,
    output logic             sysref_misalign,
    output logic [7:0]       resync_count
);

    localparam int          OPS_LOG2 = $clog2(OCTET_PER_SENT);
    localparam int          MAX_LEAD = (TX_LEAD > FM_LEAD) ? TX_LEAD : FM_LEAD;
    localparam logic [13:0] P_MAX    = 14'((1 << CNT_W) - 1);

    localparam logic [1:0] ST_CGS  = 2'd0;
    localparam logic [1:0] ST_ILAS = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    // ------------------------------------------------------------------
    // Configuration decode (from the live inputs; captured on latch)
    // ------------------------------------------------------------------
    logic [13:0] w_product;
    logic [13:0] w_period_full;
    logic        w_cfg_bad;
    logic        w_cfg_latch;

    assign w_product     = 14'(cfg_octets_per_fr) * 14'(cfg_frames_per_mf);
    assign w_period_full = w_product >> OPS_LOG2;
    assign w_cfg_bad     = (cfg_octets_per_fr == 8'd0)
                         | (cfg_frames_per_mf == 6'd0)
                         | (cfg_frames_per_mf > 6'd32)
                         | ((w_product % 14'(OCTET_PER_SENT)) != 14'd0)
                         | (w_period_full <= 14'(MAX_LEAD))
                         | (w_period_full > P_MAX);
    // Reset and cfg_load both re-capture config and restart the timing.
    assign w_cfg_latch   = reset | cfg_load;

    logic [CNT_W-1:0] r_period;
    logic             r_cfg_error;

    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (w_cfg_latch) begin
            r_period    <= w_period_full[CNT_W-1:0];
            r_cfg_error <= w_cfg_bad;
        end
    end

    // ------------------------------------------------------------------
    // SYSREF edge qualification and LMFC counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sysref_d;
    logic             r_sysref_aligned;
    logic             w_last;
    logic             w_sysref_edge;
    logic             w_mode_one;
    logic             w_mode_cont;
    logic             w_edge_used;
    logic             w_misalign;
    logic             w_mf_start;

    assign w_last        = (r_cnt == r_period - CNT_W'(1));
    assign w_sysref_edge = sysref & ~r_sysref_d;
    assign w_mode_one    = (sysref_mode == 2'd1);
    assign w_mode_cont   = (sysref_mode == 2'd2);
    assign w_edge_used   = ~r_cfg_error & w_sysref_edge
                         & (w_mode_cont | (w_mode_one & ~r_sysref_aligned));
    // An edge landing on P-1 matches the natural wrap, so it is in phase.
    assign w_misalign    = w_edge_used & ~w_last & r_sysref_aligned;
    // Realign and natural wrap both yield 0; realign wins by construction.
    assign w_cnt_next    = (r_cfg_error | w_edge_used | w_last) ? '0 : r_cnt + CNT_W'(1);
    assign w_mf_start    = ~r_cfg_error & (w_cnt_next == '0);

    logic r_lmfc;
    logic r_tx_early;
    logic r_fm_early;
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (reset) r_sysref_d <= 1'b0;
        else       r_sysref_d <= sysref;
    end

    always_ff @(posedge clk) begin
        if (w_cfg_latch) begin
            r_cnt            <= '0;
            r_lmfc           <= 1'b0;
            r_tx_early       <= 1'b0;
            r_fm_early       <= 1'b0;
            r_sysref_aligned <= 1'b0;
            r_misalign       <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            // Strobes decode the next count so they line up with cnt itself.
            r_lmfc     <= w_mf_start;
            r_tx_early <= ~r_cfg_error & (w_cnt_next == r_period - CNT_W'(TX_LEAD));
            r_fm_early <= ~r_cfg_error & (w_cnt_next == r_period - CNT_W'(FM_LEAD));
            r_misalign <= w_misalign;
            if (w_edge_used) r_sysref_aligned <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Link state machine
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [3:0] r_ilas_mf;
    logic [7:0] r_resync_count;
    logic       w_sync_any;
    logic       w_drop;
    logic       w_sysref_ok;

    assign w_sync_any  = |(sync_request & lane_enable);
    assign w_drop      = w_sync_any | (w_misalign & w_mode_cont);
    // Modes 0 and 3 do not wait for SYSREF; the aligning edge itself counts.
    assign w_sysref_ok = ~(w_mode_one | w_mode_cont) | r_sysref_aligned | w_edge_used;

    always_ff @(posedge clk) begin
        if (w_cfg_latch) begin
            r_state   <= w_cfg_bad ? ST_HALT : ST_CGS;
            r_ilas_mf <= 4'd0;
        end else if (r_cfg_error) begin
            r_state   <= ST_HALT;
            r_ilas_mf <= 4'd0;
        end else begin
            case (r_state)
                ST_CGS: begin
                    if (w_mf_start && !w_sync_any && w_sysref_ok) begin
                        r_state   <= ST_ILAS;
                        r_ilas_mf <= 4'd0;
                    end
                end
                ST_ILAS: begin
                    if (w_drop) begin
                        r_state   <= ST_CGS;
                        r_ilas_mf <= 4'd0;
                    end else if (w_mf_start) begin
                        if (r_ilas_mf == 4'(ILAS_MF - 1)) begin
                            r_state   <= ST_DATA;
                            r_ilas_mf <= 4'd0;
                        end else begin
                            r_ilas_mf <= r_ilas_mf + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_drop) r_state <= ST_CGS;
                end
                default: begin
                    r_state   <= ST_CGS;
                    r_ilas_mf <= 4'd0;
                end
            endcase
        end
    end

    // Only a hard reset clears the resync statistic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resync_count <= 8'd0;
        end else if (!cfg_load && !r_cfg_error && w_drop
                     && (r_state == ST_ILAS || r_state == ST_DATA)
                     && r_resync_count != 8'hFF) begin
            r_resync_count <= r_resync_count + 8'd1;
        end
    end

    assign lmfc            = r_lmfc;
    assign lmfc_tx_early   = r_tx_early;
    assign lmfc_fm_early   = r_fm_early;
    assign link_state      = r_state;
    assign ilas_mf         = r_ilas_mf;
    assign cfg_error       = r_cfg_error;
    assign sysref_aligned  = r_sysref_aligned;
    assign sysref_misalign = r_misalign;
    assign resync_count    = r_resync_count;

endmodule

// File: tb/tb_jesd204b_dl_lmfc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jesd204b_dl_lmfc_ctrl
//
// Purpose:
//   Directed self-checking bench for jesd204b_dl_lmfc_ctrl with default
//   parameters (4 lanes, 4 octets/beat, TX_LEAD 2, FM_LEAD 3, ILAS_MF 4).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_jesd204b_dl_lmfc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cfg_octets_per_fr;
    logic [5:0] cfg_frames_per_mf;
    logic       cfg_load;
    logic [1:0] sysref_mode;
    logic       sysref;
    logic [3:0] lane_enable;
    logic [3:0] sync_request;
    logic       lmfc;
    logic       lmfc_tx_early;
    logic       lmfc_fm_early;
    logic [1:0] link_state;
    logic [3:0] ilas_mf;
    logic       cfg_error;
    logic       sysref_aligned;
    logic       sysref_misalign;
    logic [7:0] resync_count;

    int n_assert = 0;
    int n_fail   = 0;

    jesd204b_dl_lmfc_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_octets_per_fr (cfg_octets_per_fr),
        .cfg_frames_per_mf (cfg_frames_per_mf),
        .cfg_load          (cfg_load),
        .sysref_mode       (sysref_mode),
        .sysref            (sysref),
        .lane_enable       (lane_enable),
        .sync_request      (sync_request),
        .lmfc              (lmfc),
        .lmfc_tx_early     (lmfc_tx_early),
        .lmfc_fm_early     (lmfc_fm_early),
        .link_state        (link_state),
        .ilas_mf           (ilas_mf),
        .cfg_error         (cfg_error),
        .sysref_aligned    (sysref_aligned),
        .sysref_misalign   (sysref_misalign),
        .resync_count      (resync_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input logic [7:0] f, input logic [5:0] k);
        cfg_octets_per_fr = f;
        cfg_frames_per_mf = k;
        cfg_load          = 1'b1;
        step();
        cfg_load          = 1'b0;
    endtask

    initial begin
        int waited;
        reset             = 1'b1;
        cfg_octets_per_fr = 8'd3;
        cfg_frames_per_mf = 6'd8;
        cfg_load          = 1'b0;
        sysref_mode       = 2'd0;
        sysref            = 1'b0;
        lane_enable       = 4'hF;
        sync_request      = 4'hF;
        step();
        step();

        // Reset state, P = 3*8/4 = 6
        check("rst_lmfc",      lmfc, 1'b0);
        check("rst_strobes",   {lmfc_tx_early, lmfc_fm_early}, 2'b00);
        check("rst_state",     link_state, 2'd0);
        check("rst_cfg_error", cfg_error, 1'b0);
        check("rst_aligned",   sysref_aligned, 1'b0);
        check("rst_resync",    resync_count, 8'd0);

        // Period and strobe spacing: cnt = k mod 6 after k edges
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            check("p6_lmfc", lmfc,          (k % 6) == 0);
            check("p6_tx",   lmfc_tx_early, (k % 6) == 4);
            check("p6_fm",   lmfc_fm_early, (k % 6) == 3);
        end
        check("p6_state_cgs", link_state, 2'd0);

        // Invalid config: 3*7 = 21 not a multiple of 4
        load_cfg(8'd3, 6'd7);
        check("bad_cfg_error", cfg_error, 1'b1);
        check("bad_state",     link_state, 2'd3);
        for (int k = 0; k < 8; k++) begin
            step();
            check("bad_strobes", {lmfc, lmfc_tx_early, lmfc_fm_early}, 3'b000);
        end
        check("bad_state_hold", link_state, 2'd3);

        // Recover: F=2, K=32 -> P=16
        load_cfg(8'd2, 6'd32);
        check("p16_cfg_error", cfg_error, 1'b0);
        check("p16_state",     link_state, 2'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check("p16_lmfc", lmfc, k == 16);
        end

        // SYSREF one-shot, P=6
        sysref_mode = 2'd1;
        load_cfg(8'd3, 6'd8);
        step(); step(); step();                 // cnt = 3
        sysref = 1'b1;
        step();                                 // realigned, cnt = 0
        check("os_lmfc",     lmfc, 1'b1);
        check("os_aligned",  sysref_aligned, 1'b1);
        check("os_misalign", sysref_misalign, 1'b0);
        sysref = 1'b0;
        step(); step();                         // cnt = 2
        sysref = 1'b1;
        step();                                 // ignored, cnt = 3
        check("os2_lmfc",     lmfc, 1'b0);
        check("os2_misalign", sysref_misalign, 1'b0);
        sysref = 1'b0;
        step(); step();                         // cnt = 5
        check("os2_pre_lmfc", lmfc, 1'b0);
        step();                                 // natural wrap
        check("os2_wrap_lmfc", lmfc, 1'b1);

        // Continuous mode: same off-phase edge now realigns
        sysref_mode = 2'd2;
        step(); step();                         // cnt = 2
        sysref = 1'b1;
        step();
        check("ct_lmfc",     lmfc, 1'b1);
        check("ct_misalign", sysref_misalign, 1'b1);
        sysref = 1'b0;
        step();
        check("ct_misalign_clr", sysref_misalign, 1'b0);
        check("ct_lmfc_clr",     lmfc, 1'b0);

        // Link bring-up, mode 0, all sync requests released
        sysref_mode  = 2'd0;
        sync_request = 4'h0;
        load_cfg(8'd3, 6'd8);
        for (int k = 1; k <= 30; k++) begin
            step();
            check("bu_lmfc", lmfc, (k % 6) == 0);
            if (k < 6) begin
                check("bu_cgs", link_state, 2'd0);
            end else if (k < 30) begin
                check("bu_ilas",    link_state, 2'd1);
                check("bu_ilas_mf", ilas_mf, 32'((k - 6) / 6));
            end else begin
                check("bu_data",         link_state, 2'd2);
                check("bu_data_ilas_mf", ilas_mf, 4'd0);
            end
        end

        // Resync: masked lane has no effect, enabled lane drops to CGS
        lane_enable  = 4'b1011;
        sync_request = 4'b0100;
        step();
        check("rs_masked_state",  link_state, 2'd2);
        check("rs_masked_count",  resync_count, 8'd0);
        lane_enable = 4'hF;
        step();
        check("rs_state",  link_state, 2'd0);
        check("rs_count",  resync_count, 8'd1);
        sync_request = 4'h0;

        // Back into ILAS, reach the second multiframe, then reset
        waited = 0;
        while (link_state != 2'd1 && waited < 10) begin
            step();
            waited++;
        end
        check("re_ilas_reached", link_state, 2'd1);
        waited = 0;
        while (ilas_mf != 4'd1 && waited < 10) begin
            step();
            waited++;
        end
        check("re_ilas_mf1", ilas_mf, 4'd1);
        reset = 1'b1;
        step();
        check("mr_strobes",  {lmfc, lmfc_tx_early, lmfc_fm_early}, 3'b000);
        check("mr_state",    link_state, 2'd0);
        check("mr_ilas_mf",  ilas_mf, 4'd0);
        check("mr_flags",    {sysref_aligned, sysref_misalign, cfg_error}, 3'b000);
        check("mr_resync",   resync_count, 8'd0);
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
